// File: rtl/led_fade_pwm.sv
// RGB fade-to-target PWM driver: registered requests ramp per-channel levels one step per prescaler tick.
// Optional LED_FADE_GAMMA_EN applies a quadratic duty curve (level*level >> PWM_BITS); default is linear.
module led_fade_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_r,
  input  logic                in_g,
  input  logic                in_b,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic [PWM_BITS-1:0] level_r,
  output logic [PWM_BITS-1:0] level_g,
  output logic [PWM_BITS-1:0] level_b,
  output logic                busy
);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  logic [2:0]          req_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] lvl_q [3];
  logic [PWM_BITS-1:0] lvl_d [3];
  logic [2:0]          led_q, led_d;
  logic [2:0]          ch_busy;
  logic                step_tick;

  assign step_tick = (pre_q == PRE_W'(STEP_DIV - 1));
  assign pre_d     = step_tick ? '0 : pre_q + 1'b1;
  assign pwm_d     = pwm_q + 1'b1;

  always_comb begin
    logic [PWM_BITS-1:0]   duty;
`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
`endif
    duty    = '0;
`ifdef LED_FADE_GAMMA_EN
    sq      = '0;
`endif
    ch_busy = '0;
    led_d   = '0;
    for (int c = 0; c < 3; c++) begin
      lvl_d[c] = lvl_q[c];
      // Saturating step toward the sampled request; reversal just changes direction from here.
      if (step_tick) begin
        if (req_q[c] && (lvl_q[c] != MAX))
          lvl_d[c] = lvl_q[c] + 1'b1;
        else if (!req_q[c] && (lvl_q[c] != '0))
          lvl_d[c] = lvl_q[c] - 1'b1;
      end
`ifdef LED_FADE_GAMMA_EN
      sq   = {{PWM_BITS{1'b0}}, lvl_q[c]} * {{PWM_BITS{1'b0}}, lvl_q[c]};
      duty = sq[2*PWM_BITS-1:PWM_BITS];
`else
      duty = lvl_q[c];
`endif
      led_d[c]   = (lvl_q[c] == MAX) | (duty > pwm_q);
      ch_busy[c] = req_q[c] ? (lvl_q[c] != MAX) : (lvl_q[c] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
      pre_q <= '0;
      pwm_q <= '0;
      led_q <= '0;
      for (int c = 0; c < 3; c++) lvl_q[c] <= '0;
    end else begin
      req_q <= {in_b, in_g, in_r};
      pre_q <= pre_d;
      pwm_q <= pwm_d;
      led_q <= led_d;
      for (int c = 0; c < 3; c++) lvl_q[c] <= lvl_d[c];
    end
  end

  assign led_r   = led_q[0];
  assign led_g   = led_q[1];
  assign led_b   = led_q[2];
  assign level_r = lvl_q[0];
  assign level_g = lvl_q[1];
  assign level_b = lvl_q[2];
  assign busy    = |ch_busy;

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream stage of the blink generator. Consumes its raw on/off levels (led_r/led_g/led_b) and drives the physical RGB pins.
- Each channel's brightness ramps smoothly up or down toward the requested on/off state, instead of switching hard.
- Brightness is rendered as PWM. A shared free-running PWM counter and a shared step prescaler serve all three channels.

Parameters:
- PWM_BITS, 8, width of the PWM counter and of each per-channel level register; MAX = 2^PWM_BITS-1.
- STEP_DIV, 4096, clocks per brightness step (prescaler period); legal range 1..2^20.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (assert 0, release synchronously to clk upstream).
- in_r  input  1  requested state, red (1 = fade to full, 0 = fade to off).
- in_g  input  1  requested state, green.
- in_b  input  1  requested state, blue.
- led_r  output  1  PWM drive, red.
- led_g  output  1  PWM drive, green.
- led_b  output  1  PWM drive, blue.
- level_r  output  PWM_BITS  current red brightness level.
- level_g  output  PWM_BITS  current green brightness level.
- level_b  output  PWM_BITS  current blue brightness level.
- busy  output  1  high while any channel level differs from its target.

Behaviour:
- Reset (rst=0, async):
  - input regs, levels, pwm_cnt and prescaler go to 0;
  - led_* go to 0; busy goes to 0.
  - Reset mid-ramp discards all progress.
- Input stage: in_* registered once (req_*); all later logic uses req_*.
- Prescaler: counts 0..STEP_DIV-1, wraps to 0. step_tick is high for the one cycle where count==STEP_DIV-1. With STEP_DIV=1, step_tick is high every cycle.
- pwm_cnt: free-running PWM_BITS counter, increments every cycle, wraps MAX->0. Unaffected by inputs.
- Per-channel level, updated only on step_tick:
  - req=1 and level<MAX -> level+1;
  - req=0 and level>0 -> level-1;
  - otherwise hold (saturate at 0/MAX, never wraps).
- Direction reversal mid-ramp: takes effect on the next step_tick from the current level, with no jump.
- Per-channel state, reported only via level/busy: OFF (level=0, req=0), RISE (req=1, level<MAX), ON (level=MAX, req=1), FALL (req=0, level>0).
- Full ramp 0->MAX takes MAX step_ticks.
- duty compare value d: d = level (linear; see optional feature).
- led_x registered each cycle: led_x <= (level==MAX) | (d > pwm_cnt).
  - level=0 gives constant 0.
  - level=MAX gives constant 1.
  - Otherwise led_x is high for d of every 2^PWM_BITS cycles.
  - Latency level->led is 1 cycle.
- busy (combinational from registers): OR over channels of (req=1 & level!=MAX) | (req=0 & level!=0).
- Input toggling faster than step_tick: only the req value sampled at each step_tick matters.

Optional Feature:
- Macro LED_FADE_GAMMA_EN.
- Defined: d = (level*level) >> PWM_BITS, an approximately quadratic perceptual curve. The product is 2*PWM_BITS wide. The level==MAX override still forces constant 1.
- Undefined: d = level (linear). No multiplier is synthesised.
- level_* outputs and busy are identical in both builds.

Test Plan (bench uses PWM_BITS=4, STEP_DIV=2, MAX=15):
- Reset then in_*=0 for 100 cycles -> levels 0, led_* constantly 0, busy 0. Hold rst=0 mid-run -> all outputs 0 immediately, without waiting for a clk edge.
- Set in_r=1 at cycle 0 -> level_r rises by 1 every 2 cycles and reaches 15 within 32 cycles. busy=1 throughout, falls to 0 the cycle level_r hits 15. led_r then constant 1.
- Hold level_r at 8 (in_r=1 then in_r=0 timed at level 8, linear build) -> freeze via STEP_DIV large rebuild or sample one PWM period: led_r high exactly 8 of 16 cycles.
- From level_g=15, set in_g=0; after level_g reaches 10, set in_g=1 -> level_g turns 10->11 on the next tick, never wraps or jumps, and returns to 15.
- Saturation: in_b=1 held 200 cycles -> level_b stays 15. Then in_b=0 held 200 cycles -> level_b stays 0, with no wrap to 15.
- LED_FADE_GAMMA_EN build, level=8 -> d=4, led high 4 of 16 cycles. level=15 -> constant 1. level=3 -> d=0, led constant 0.
